seq_det_scheduler: RTL and testbench
====================================

// Module: seq_det_scheduler
// PURPOSE
//  Shares one serial bit-pattern matching engine (Moore-style PAT_W-bit detector) among NREQ requesters.
//  Round-robin arbiter grants one requester, latches its word and pattern, shifts the word MSB-first
//  through the detector, then reports match count and first match position. Sits between
//  software-visible/upstream word sources and the serial detection datapath.
// PARAMETERS
//  NREQ    4   number of requesters (>=2)
//  WORD_W  16  bits per scanned word (>=PAT_W)
//  PAT_W   4   pattern length in bits
//  CNT_W   5   width of match_cnt/first_pos; must hold WORD_W
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             asynchronous active-high reset
//  req        in   NREQ          per-requester request level; held until granted
//  word_in    in   NREQ*WORD_W   requester i word at [i*WORD_W +: WORD_W]
//  pattern    in   PAT_W         pattern, MSB = first bit expected
//  gnt        out  NREQ          one-hot grant, 1-cycle pulse
//  busy       out  1             high from grant cycle through done cycle
//  done       out  1             1-cycle result strobe
//  done_id    out  $clog2(NREQ)  index of requester whose result is on done
//  match_cnt  out  CNT_W         matches found in word
//  first_pos  out  CNT_W         bit index (0 = MSB) completing first match; all-ones if none
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, history/counters 0, RR pointer -> requester 0 highest priority.
//  FSM IDLE -> SHIFT -> DONE -> IDLE; no other states, default -> IDLE.
//  IDLE: if |req, pick first set req at or after RR pointer (wrapping); assert gnt[i], busy;
//   latch word_in[i], pattern, id; pointer <= i+1 mod NREQ; go SHIFT. No req -> stay, outputs 0.
//  SHIFT: exactly WORD_W cycles, bit index k=0..WORD_W-1, bit = word[WORD_W-1-k].
//   history <= {history[PAT_W-2:0], bit}; seen <= sat(seen+1).
//   match when new history == latched pattern and new seen >= PAT_W.
//   On match: match_cnt+1 (saturating at all-ones); first match sets first_pos=k.
//  DONE: done=1 one cycle, busy=1, done_id/match_cnt/first_pos valid; held until next DONE.
//   Next cycle IDLE; new grant possible that cycle.
//  Latency: gnt at cycle t -> done at t+WORD_W+1; throughput one word per WORD_W+2 cycles.
//  req/pattern changes after grant ignored; requester must drop req the cycle after gnt
//   (req still high in IDLE is treated as a new request).
//  Simultaneous req: only one grant per IDLE visit; losers keep priority order via pointer.
//  rst mid-operation: immediate abort, no done emitted, state as reset.
//  Pattern may be any value incl. all-zeros/all-ones; no special casing.
// CONFIGURATION
//  SEQ_DET_SCHED_OVERLAP_EN defined: overlapping matches counted (seen not cleared on match).
//  Not defined (default): seen cleared to 0 on each match, next match needs PAT_W fresh bits;
//   history register itself keeps shifting.
// TESTING
//  pattern=4'b1011, req=0001, word0=16'hB000 -> gnt=0001, done 17 cyc later, cnt=1, pos=3, id=0.
//  pattern=1011, word=16'b1011011011000000 -> no OVERLAP_EN: cnt=2,pos=3; with OVERLAP_EN: cnt=3,pos=3.
//  pattern=1011, word=16'h0000 -> cnt=0, first_pos=5'b11111.
//  req=1111 held after each grant until all served -> grant order 0,1,2,3; then req=1001 -> 0 then 3.
//  rst pulsed at 5th SHIFT cycle -> no done, gnt/busy=0; next req=0100 -> gnt=0100 (pointer=0 base).
//  pattern=1111, word=16'hFFFF, OVERLAP_EN -> cnt=13, pos=3; without -> cnt=4, pos=3.

Source files
------------

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin front end that shares one serial PAT_W-bit
// pattern detector among NREQ requesters. A granted word is shifted MSB-first
// through the detector, and the match count and first match position are
// reported on a one-cycle done strobe.
// Build option: define SEQ_DET_SCHED_OVERLAP_EN to count overlapping matches.
// Without it, each match consumes its bits, so the next match needs PAT_W
// fresh bits.
module seq_det_scheduler #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WORD_W-1:0]     word_in,
  input  logic [PAT_W-1:0]           pattern,
  output logic [NREQ-1:0]            gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NREQ)-1:0]    done_id,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           first_pos
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id_q;
  logic [WORD_W-1:0] word_q;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  hist;
  logic [CNT_W-1:0]  seen;
  logic [CNT_W-1:0]  bit_k;
  logic [CNT_W-1:0]  cnt_acc;
  logic [CNT_W-1:0]  pos_acc;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   ptr_nx;
  logic [PAT_W-1:0]  hist_nx;
  logic [CNT_W-1:0]  seen_nx;
  logic              hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Round-robin pick: first set request at or after ptr, wrapping around.
  // The loop runs from the farthest offset down so the nearest one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      int idx;
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
    ptr_nx = (pick_id == ID_W'(NREQ - 1)) ? '0 : pick_id + 1'b1;
  end

  // Detector step for the current MSB of the latched word.
  always_comb begin
    hist_nx = {hist[PAT_W-2:0], word_q[WORD_W-1]};
    seen_nx = sat_inc(seen);
    hit     = (hist_nx == pat_q) && (seen_nx >= CNT_W'(PAT_W));
  end

  // Control FSM, detector state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      word_q    <= '0;
      pat_q     <= '0;
      hist      <= '0;
      seen      <= '0;
      bit_k     <= '0;
      cnt_acc   <= '0;
      pos_acc   <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      first_pos <= '0;
    end else begin
      case (state)
        IDLE: begin
          gnt  <= '0;
          busy <= 1'b0;
          done <= 1'b0;
          if (pick_vld) begin
            gnt     <= NREQ'(1) << pick_id;
            busy    <= 1'b1;
            word_q  <= word_in[pick_id*WORD_W +: WORD_W];
            pat_q   <= pattern;
            id_q    <= pick_id;
            ptr     <= ptr_nx;
            hist    <= '0;
            seen    <= '0;
            bit_k   <= '0;
            cnt_acc <= '0;
            // All-ones marks "no match yet"; it is larger than any bit index.
            pos_acc <= '1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          gnt    <= '0;
          word_q <= word_q << 1;
          hist   <= hist_nx;
          bit_k  <= bit_k + 1'b1;
          if (hit) begin
            cnt_acc <= sat_inc(cnt_acc);
            if (&pos_acc) pos_acc <= bit_k;
`ifdef SEQ_DET_SCHED_OVERLAP_EN
            seen <= seen_nx;
`else
            seen <= '0;
`endif
          end else begin
            seen <= seen_nx;
          end
          if (bit_k == CNT_W'(WORD_W - 1)) state <= DONE;
        end
        DONE: begin
          done      <= 1'b1;
          done_id   <= id_q;
          match_cnt <= cnt_acc;
          first_pos <= pos_acc;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: directed scenarios plus randomized request
// sets, all checked against a behavioural model of arbitration and matching.
module tb_seq_det_scheduler;

  localparam int NREQ   = 4;
  localparam int WORD_W = 16;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 5;
`ifdef SEQ_DET_SCHED_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WORD_W-1:0] word_in = '0;
  logic [PAT_W-1:0]       pattern = '0;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   done;
  logic [1:0]             done_id;
  logic [CNT_W-1:0]       match_cnt;
  logic [CNT_W-1:0]       first_pos;

  int checks = 0;
  int passes = 0;
  int rr_ptr = 0;

  seq_det_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .word_in(word_in), .pattern(pattern),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .match_cnt(match_cnt), .first_pos(first_pos)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a match completes at bit k when the last PAT_W bits read equal
  // the pattern; without overlap, the previous match must lie PAT_W or more
  // bits earlier.
  function automatic void ref_scan(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                                   output int cnt, output int pos);
    int last;
    logic [WORD_W-1:0] sh;
    last = -1;
    cnt  = 0;
    pos  = 31;
    for (int k = PAT_W - 1; k < WORD_W; k++) begin
      sh = w >> (WORD_W - 1 - k);
      if (sh[PAT_W-1:0] == p && (OVL || (k - last) >= PAT_W)) begin
        if (cnt < 31) cnt++;
        if (pos == 31) pos = k;
        last = k;
      end
    end
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (m[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  // Waits for the expected grant, drops that request, scrambles the pattern
  // and the granted word (both must already be latched), then checks the result.
  task automatic serve_one(input int exp_id, output int got_cnt, output int got_pos);
    int n;
    int m;
    int e_cnt;
    int e_pos;
    logic [PAT_W-1:0]  p_at;
    logic [WORD_W-1:0] w_at;
    got_cnt = -1;
    got_pos = -1;
    n = 0;
    while (gnt === '0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("gnt_seen", 32'(n < 40), 32'd1);
    if (n >= 40) return;
    chk("gnt_id", 32'(gnt), 32'(4'b0001 << exp_id));
    chk("busy_at_gnt", 32'(busy), 32'd1);
    p_at = pattern;
    w_at = word_in[exp_id*WORD_W +: WORD_W];
    ref_scan(w_at, p_at, e_cnt, e_pos);
    req[exp_id] = 1'b0;
    pattern = PAT_W'($urandom);
    word_in[exp_id*WORD_W +: WORD_W] = WORD_W'($urandom);
    rr_ptr = (exp_id + 1) % NREQ;
    m = 0;
    do begin
      @(posedge clk); #1; m++;
    end while (done !== 1'b1 && m < 40);
    chk("done_latency", 32'(m), 32'(WORD_W + 1));
    if (m >= 40) return;
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("done_id", 32'(done_id), 32'(exp_id));
    chk("match_cnt", 32'(match_cnt), 32'(e_cnt));
    chk("first_pos", 32'(first_pos), 32'(e_pos));
    got_cnt = int'(match_cnt);
    got_pos = int'(first_pos);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic directed(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                          input int exp_cnt, input int exp_pos, input string tag);
    int c;
    int q;
    word_in[0 +: WORD_W] = w;
    pattern = p;
    req = 4'b0001;
    serve_one(0, c, q);
    chk({tag, "_cnt"}, 32'(c), 32'(exp_cnt));
    chk({tag, "_pos"}, 32'(q), 32'(exp_pos));
  endtask

  initial begin
    int c;
    int q;
    int e;
    int dcount;
    logic [NREQ-1:0] mask;

    // Reset state
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_pos", 32'(first_pos), 32'd0);
    chk("rst_id", 32'(done_id), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_gnt", 32'(gnt), 32'd0);
    rr_ptr = 0;

    // All four requesters held: served in order 0,1,2,3
    for (int i = 0; i < NREQ; i++) word_in[i*WORD_W +: WORD_W] = WORD_W'($urandom);
    pattern = 4'b1011;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) serve_one(i, c, q);
    // Then 1001: 0 first, then 3
    word_in[0 +: WORD_W] = 16'hB000;
    word_in[3*WORD_W +: WORD_W] = 16'hB6C0;
    req = 4'b1001;
    serve_one(0, c, q);
    serve_one(3, c, q);

    // Directed pattern cases on requester 0
    directed(16'hB000, 4'b1011, 1, 3, "single");
    directed(16'hB6C0, 4'b1011, OVL ? 3 : 2, 3, "overlap");
    directed(16'h0000, 4'b1011, 0, 31, "nomatch");
    directed(16'hFFFF, 4'b1111, OVL ? 13 : 4, 3, "ones");
    directed(16'h0000, 4'b0000, OVL ? 13 : 4, 3, "zeros");

    // Reset during the fifth SHIFT cycle aborts the scan
    word_in[0 +: WORD_W] = 16'hB6C0;
    pattern = 4'b1011;
    req = 4'b0001;
    e = 0;
    while (gnt === '0 && e < 40) begin
      @(posedge clk); #1; e++;
    end
    chk("abort_gnt", 32'(gnt), 32'd1);
    req = '0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_gnt0", 32'(gnt), 32'd0);
    chk("abort_busy0", 32'(busy), 32'd0);
    #2 rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    rr_ptr = 0;
    word_in[2*WORD_W +: WORD_W] = 16'hB000;
    req = 4'b0100;
    serve_one(2, c, q);
    chk("after_rst_cnt", 32'(c), 32'd1);

    // Randomized request sets against the model
    for (int it = 0; it < 15; it++) begin
      mask = NREQ'($urandom_range(1, 15));
      case ($urandom_range(0, 3))
        0: pattern = '0;
        1: pattern = '1;
        default: pattern = PAT_W'($urandom);
      endcase
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) == 0) word_in[i*WORD_W +: WORD_W] = {4{pattern}};
        else word_in[i*WORD_W +: WORD_W] = WORD_W'($urandom);
      end
      req = mask;
      while (mask != '0) begin
        e = rr_pick(mask, rr_ptr);
        serve_one(e, c, q);
        mask[e] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
